// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the multistage MIPS pipeline.
// Holds the PC, drives the instruction-memory address, latches the fetched word,
// and applies ID-stage redirects, hazard stalls and exception flushes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter logic [3:0]  EXC_ADEL   = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        exc_flush,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [3:0]  if_id_exc,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [3:0]  exc_q, exc_d;

    logic [31:0] pc4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        redirect;

    // Target arithmetic; all sums wrap silently modulo 2^32.
    assign pc4           = pc_q + 32'd4;
    assign branch_target = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jump_target   = {pc4_q[31:28], instr_q[25:0], 2'b00};

    // Redirect requests only count when ID holds a real instruction.
    assign redirect = valid_q & (jr | jump | branch_taken);

    // Next-PC selection and IF/ID update, highest priority first.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        exc_d   = exc_q;

        if (exc_flush) begin
            pc_d    = EXC_VECTOR;
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            exc_d   = 4'd0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            if (jr) begin
                pc_d = jr_addr;
            end else if (jump) begin
                pc_d = jump_target;
            end else begin
                pc_d = branch_target;
            end
            // Wrong-path fetch is squashed: no delay slot.
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            exc_d   = 4'd0;
        end else begin
            pc_d    = pc4;
            pc4_d   = pc4;
            valid_d = 1'b1;
            if (pc_q[1:0] == 2'b00) begin
                instr_d = imem_rdata;
                exc_d   = 4'd0;
            end else begin
                instr_d = NOP_INSTR;
                exc_d   = EXC_ADEL;
            end
        end
    end

    // PC and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            exc_q   <= 4'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            exc_q   <= exc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign if_id_exc   = exc_q;

    // Decode fields are plain slices of the latched instruction.
    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];
    assign imm16  = instr_q[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, branch, jump, stall, JR to a
// misaligned address, exception flush and reset during stall.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        exc_flush;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [3:0]  if_id_exc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .exc_flush    (exc_flush),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .if_id_exc    (if_id_exc),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
        .imm16        (imm16)
    );

    always #5 clk = ~clk;

    // Small instruction memory; misaligned reads return garbage that must never be latched.
    always_comb begin
        imem_rdata = 32'h0000_0000;
        if (imem_addr[1:0] != 2'b00) begin
            imem_rdata = 32'hDEAD_BEEF;
        end else begin
            case (imem_addr)
                32'h0000_3000: imem_rdata = 32'h2008_0005;
                32'h0000_3010: imem_rdata = 32'h1000_FFFF;
                32'h0000_3020: imem_rdata = 32'h0800_0C10;
                32'h0000_3040: imem_rdata = 32'h1000_0003;
                32'h0000_304C: imem_rdata = 32'h2409_1234;
                default:       imem_rdata = 32'h0000_0000;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid, input logic [3:0] exc);
        chk({tag, "_pc"},    imem_addr, pc);
        chk({tag, "_instr"}, if_id_instr, instr);
        chk({tag, "_pc4"},   if_id_pc4, pc4);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'(valid));
        chk({tag, "_exc"},   32'(if_id_exc), 32'(exc));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; exc_flush = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; jr_addr = 32'd0;
        #1;
        step();
        chk_ifid("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 4'd0);

        // Free-running sequential fetch
        rst_n = 1'b1;
        step();
        chk_ifid("seq1", 32'h3004, 32'h2008_0005, 32'h3004, 1'b1, 4'd0);
        chk("seq1_opcode", 32'(opcode), 32'h08);
        chk("seq1_rt",     32'(rt),     32'd8);
        chk("seq1_imm16",  32'(imm16),  32'h0005);
        step();
        chk("seq2_pc", imem_addr, 32'h3008);
        step();
        chk("seq3_pc", imem_addr, 32'h300C);
        step();
        step();
        chk_ifid("beq_latched", 32'h3014, 32'h1000_FFFF, 32'h3014, 1'b1, 4'd0);

        // Taken backward branch: target 0x3014 - 4
        branch_taken = 1'b1;
        step();
        chk_ifid("beq_taken", 32'h3010, 32'h0, 32'h0, 1'b0, 4'd0);
        // branch_taken still high but IF/ID is a bubble, so it is ignored
        step();
        chk_ifid("beq_ignored", 32'h3014, 32'h1000_FFFF, 32'h3014, 1'b1, 4'd0);
        branch_taken = 1'b0;

        // Walk to the J at 0x3020
        step(); step(); step(); step();
        chk_ifid("j_latched", 32'h3024, 32'h0800_0C10, 32'h3024, 1'b1, 4'd0);
        jump = 1'b1;
        step();
        chk_ifid("j_taken", 32'h3040, 32'h0, 32'h0, 1'b0, 4'd0);
        jump = 1'b0;
        step();
        chk_ifid("beq2_latched", 32'h3044, 32'h1000_0003, 32'h3044, 1'b1, 4'd0);

        // Stall wins over a simultaneous branch for two cycles
        stall = 1'b1; branch_taken = 1'b1;
        step();
        chk_ifid("stall1", 32'h3044, 32'h1000_0003, 32'h3044, 1'b1, 4'd0);
        step();
        chk_ifid("stall2", 32'h3044, 32'h1000_0003, 32'h3044, 1'b1, 4'd0);
        stall = 1'b0;
        step();
        chk_ifid("post_stall_br", 32'h3050, 32'h0, 32'h0, 1'b0, 4'd0);
        branch_taken = 1'b0;
        step();
        chk_ifid("fetch_3050", 32'h3054, 32'h0, 32'h3054, 1'b1, 4'd0);

        // JR to a misaligned address raises AdEL on the next fetch
        jr = 1'b1; jr_addr = 32'h3002;
        step();
        chk_ifid("jr_taken", 32'h3002, 32'h0, 32'h0, 1'b0, 4'd0);
        jr = 1'b0;
        step();
        chk_ifid("adel", 32'h3006, 32'h0, 32'h3006, 1'b1, 4'd4);

        // Exception flush beats stall
        exc_flush = 1'b1; stall = 1'b1;
        step();
        chk_ifid("exc_flush", 32'h4180, 32'h0, 32'h0, 1'b0, 4'd0);
        exc_flush = 1'b0; stall = 1'b0;
        step();
        chk_ifid("fetch_4180", 32'h4184, 32'h0, 32'h4184, 1'b1, 4'd0);

        // JR to 0x304C then fetch a word exercising every field slice
        jr = 1'b1; jr_addr = 32'h304C;
        step();
        chk("jr2_pc", imem_addr, 32'h304C);
        jr = 1'b0;
        step();
        chk_ifid("addiu", 32'h3050, 32'h2409_1234, 32'h3050, 1'b1, 4'd0);
        chk("f_opcode", 32'(opcode), 32'd9);
        chk("f_rs",     32'(rs),     32'd0);
        chk("f_rt",     32'(rt),     32'd9);
        chk("f_rd",     32'(rd),     32'd2);
        chk("f_shamt",  32'(shamt),  32'd8);
        chk("f_funct",  32'(funct),  32'h34);
        chk("f_imm16",  32'(imm16),  32'h1234);

        // Reset during a stall with a pending redirect wins unconditionally
        stall = 1'b1;
        step();
        chk("hold_3050", imem_addr, 32'h3050);
        rst_n = 1'b0; jr = 1'b1; jr_addr = 32'h5000;
        step();
        chk_ifid("reset_in_stall", 32'h3000, 32'h0, 32'h0, 1'b0, 4'd0);
        chk("reset_opcode", 32'(opcode), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
